// File: rtl/rle_pkg.sv
// Shared definitions for the parametrised run-length encoder.
// Contents: FSM state encoding, out_data field positions, and the maximum
// run count as a function of the count-field width.
package rle_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    LOAD = 3'd3,
    SCAN = 3'd4,
    EMIT = 3'd5,
    DONE = 3'd6
  } state_t;

  // The run count sits in the low bits and the bit value directly above it.
  localparam int CNT_LSB = 0;

  function automatic int val_pos(input int cnt_w);
    return cnt_w;
  endfunction

  function automatic longint unsigned maxc_of(input int cnt_w);
    return (64'd1 << cnt_w) - 64'd1;
  endfunction

endpackage

// File: rtl/rle_bit_sel.sv
// Picks the bit currently being scanned out of the buffered input word.
// Ports:
//   shift_buf - buffered input word
//   bit_idx   - scan position, 0 = first bit scanned
//   b         - selected bit
module rle_bit_sel #(
  parameter int IN_W      = 8,
  parameter bit LSB_FIRST = 1'b1,
  parameter int IDX_W     = $clog2(IN_W)
) (
  input  logic [IN_W-1:0]  shift_buf,
  input  logic [IDX_W-1:0] bit_idx,
  output logic             b
);

  // Bit-reversed copy so both scan orders index with bit_idx directly.
  logic [IN_W-1:0] rev_buf;

  always_comb begin
    rev_buf = '0;
    for (int i = 0; i < IN_W; i++) begin
      rev_buf[i] = shift_buf[IN_W-1-i];
    end
  end

  always_comb begin
    if (LSB_FIRST) begin
      b = shift_buf[bit_idx];
    end else begin
      b = rev_buf[bit_idx];
    end
  end

endmodule

// File: rtl/rle_enc_param.sv
// Run-length encoder between an input FIFO and an output FIFO.
// Reads IN_W-bit words, scans them one bit per cycle and writes
// {bit_value, run_count} words. Runs span word boundaries, saturate at
// MAXC (splitting into several words) and are flushed on end_of_stream.
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   recv_ready     - input FIFO not empty
//   rd_req         - input FIFO read pulse
//   in_data        - input FIFO data, sampled in LOAD
//   end_of_stream  - no more input once the FIFO drains
//   send_ready     - output FIFO not full
//   wr_req         - output FIFO write pulse
//   out_data       - {bit_value, run_count}
//   done           - one-cycle pulse after end-of-stream handling
//   busy           - high in every state except IDLE and REQ
//
// state | meaning
// IDLE  | clear run state, start a new stream
// REQ   | wait for input word or end_of_stream
// WAIT  | read request issued, data in flight
// LOAD  | capture input word
// SCAN  | consume one bit per cycle
// EMIT  | present finished run, wait for output space
// DONE  | pulse done
module rle_enc_param
  import rle_pkg::*;
#(
  parameter int IN_W      = 8,
  parameter int CNT_W     = 23,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             recv_ready,
  output logic             rd_req,
  input  logic [IN_W-1:0]  in_data,
  input  logic             end_of_stream,
  input  logic             send_ready,
  output logic             wr_req,
  output logic [CNT_W:0]   out_data,
  output logic             done,
  output logic             busy
);

  localparam int                IDX_W    = $clog2(IN_W);
  localparam int                VAL_POS  = val_pos(CNT_W);
  localparam logic [CNT_W-1:0]  MAXC     = CNT_W'(maxc_of(CNT_W));
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(IN_W - 1);

  state_t            state;
  logic [IN_W-1:0]   shift_buf;
  logic [IDX_W-1:0]  bit_idx;
  logic              value;
  logic [CNT_W-1:0]  count;
  logic              active;
  logic              flush;
  logic              b;

  rle_bit_sel #(
    .IN_W      (IN_W),
    .LSB_FIRST (LSB_FIRST),
    .IDX_W     (IDX_W)
  ) u_bit_sel (
    .shift_buf (shift_buf),
    .bit_idx   (bit_idx),
    .b         (b)
  );

  assign busy = (state != IDLE) && (state != REQ);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rd_req    <= 1'b0;
      wr_req    <= 1'b0;
      out_data  <= '0;
      done      <= 1'b0;
      shift_buf <= '0;
      bit_idx   <= '0;
      value     <= 1'b0;
      count     <= '0;
      active    <= 1'b0;
      flush     <= 1'b0;
    end else begin
      rd_req <= 1'b0;
      wr_req <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          active <= 1'b0;
          count  <= '0;
          flush  <= 1'b0;
          state  <= REQ;
        end
        REQ: begin
          if (recv_ready) begin
            rd_req <= 1'b1;
            state  <= WAIT;
          end else if (end_of_stream && active) begin
            flush                     <= 1'b1;
            out_data[VAL_POS]         <= value;
            out_data[VAL_POS-1:CNT_LSB] <= count;
            state                     <= EMIT;
          end else if (end_of_stream) begin
            state <= DONE;
          end
        end
        WAIT: begin
          state <= LOAD;
        end
        LOAD: begin
          shift_buf <= in_data;
          bit_idx   <= '0;
          state     <= SCAN;
        end
        SCAN: begin
          if (!active || (b == value && count != MAXC)) begin
            if (!active) begin
              value  <= b;
              count  <= CNT_W'(1);
              active <= 1'b1;
            end else begin
              count <= count + CNT_W'(1);
            end
            if (bit_idx == LAST_IDX) begin
              state <= REQ;
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end else begin
            // Bit stays unconsumed; it opens the next run after EMIT.
            out_data[VAL_POS]           <= value;
            out_data[VAL_POS-1:CNT_LSB] <= count;
            state                       <= EMIT;
          end
        end
        EMIT: begin
          if (send_ready) begin
            wr_req <= 1'b1;
            active <= 1'b0;
            count  <= '0;
            state  <= flush ? DONE : SCAN;
          end
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rle_enc_param.sv
// Scoreboard bench for rle_enc_param. Three instances run side by side on
// identical stimulus: default (LSB first, 23-bit count), MSB first, and a
// 3-bit count to exercise saturation splitting.
module tb_rle_enc_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       send_ready;
  logic       recv_ready [3];
  logic       rd_req     [3];
  logic [7:0] in_data    [3];
  logic       eos        [3];
  logic       wr_req     [3];
  logic       done       [3];
  logic       busy       [3];
  logic [23:0] od0, od1;
  logic [3:0]  od2;
  int unsigned od [3];

  logic [7:0]  in_q  [3][$];
  int unsigned exp_q [3][$];
  int          wr_cnt   [3];
  int          done_cnt [3];
  bit          overlap  [3];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign od[0] = 32'(od0);
  assign od[1] = 32'(od1);
  assign od[2] = 32'(od2);

  rle_enc_param u_lsb (
    .clk(clk), .rst(rst), .recv_ready(recv_ready[0]), .rd_req(rd_req[0]),
    .in_data(in_data[0]), .end_of_stream(eos[0]), .send_ready(send_ready),
    .wr_req(wr_req[0]), .out_data(od0), .done(done[0]), .busy(busy[0])
  );

  rle_enc_param #(.IN_W(8), .CNT_W(23), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst(rst), .recv_ready(recv_ready[1]), .rd_req(rd_req[1]),
    .in_data(in_data[1]), .end_of_stream(eos[1]), .send_ready(send_ready),
    .wr_req(wr_req[1]), .out_data(od1), .done(done[1]), .busy(busy[1])
  );

  rle_enc_param #(.IN_W(8), .CNT_W(3), .LSB_FIRST(1'b1)) u_sat (
    .clk(clk), .rst(rst), .recv_ready(recv_ready[2]), .rd_req(rd_req[2]),
    .in_data(in_data[2]), .end_of_stream(eos[2]), .send_ready(send_ready),
    .wr_req(wr_req[2]), .out_data(od2), .done(done[2]), .busy(busy[2])
  );

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic int unsigned enc(input int k, input int unsigned v, input int unsigned c);
    return (k == 2) ? ((v << 3) | c) : ((v << 23) | c);
  endfunction

  // Input FIFO model: data appears after the read pulse and holds.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (rd_req[k] && in_q[k].size() != 0) in_data[k] = in_q[k].pop_front();
        recv_ready[k] = (in_q[k].size() != 0);
      end
    end
  end

  // Monitor: every write is matched against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (wr_req[k]) begin
          wr_cnt[k]++;
          if (exp_q[k].size() == 0) begin
            $display("FAIL unexpected_write dut%0d: got 0x%0h, expected no write", k, od[k]);
            n_checks++;
          end else begin
            check($sformatf("write dut%0d", k), od[k], exp_q[k].pop_front());
          end
        end
        if (done[k]) done_cnt[k]++;
        if (rd_req[k] && wr_req[k]) overlap[k] = 1'b1;
      end
    end
  end

  task automatic push_all(input logic [7:0] w);
    for (int k = 0; k < 3; k++) begin
      in_q[k].push_back(w);
      recv_ready[k] = 1'b1;
    end
  endtask

  task automatic expect_run(input int k, input int unsigned v, input int unsigned c, input int n);
    for (int i = 0; i < n; i++) exp_q[k].push_back(enc(k, v, c));
  endtask

  // Raise end_of_stream, drop it per instance once its done pulse is seen.
  task automatic finish_stream(input string name);
    int  d0 [3];
    bit  seen [3];
    int  cyc;
    for (int k = 0; k < 3; k++) begin
      d0[k] = done_cnt[k];
      seen[k] = 1'b0;
      eos[k] = 1'b1;
    end
    cyc = 0;
    while (!(seen[0] && seen[1] && seen[2]) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      for (int k = 0; k < 3; k++) begin
        if (done[k]) begin
          seen[k] = 1'b1;
          eos[k] = 1'b0;
        end
      end
    end
    for (int k = 0; k < 3; k++) eos[k] = 1'b0;
    if (cyc >= 2000) begin
      $display("FAIL %s timeout: got no done, expected done within 2000 cycles", name);
      n_checks++;
    end
    repeat (6) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s pending dut%0d", name, k), exp_q[k].size(), 0);
      check($sformatf("%s done dut%0d", name, k), done_cnt[k] - d0[k], 1);
    end
  endtask

  initial begin
    int  wc [3];
    bit  hold_bad [3];
    rst = 1'b1;
    send_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      recv_ready[k] = 1'b0;
      in_data[k] = '0;
      eos[k] = 1'b0;
      wr_cnt[k] = 0;
      done_cnt[k] = 0;
      overlap[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset out_data dut%0d", k), od[k], 0);
      check($sformatf("reset flags dut%0d", k),
            {28'd0, rd_req[k], wr_req[k], done[k], busy[k]}, 0);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 0x0F
    push_all(8'h0F);
    expect_run(0, 1, 4, 1); expect_run(0, 0, 4, 1);
    expect_run(1, 0, 4, 1); expect_run(1, 1, 4, 1);
    expect_run(2, 1, 4, 1); expect_run(2, 0, 4, 1);
    finish_stream("t0f");

    // run spanning a word boundary
    push_all(8'hFF); push_all(8'hFF);
    expect_run(0, 1, 16, 1);
    expect_run(1, 1, 16, 1);
    expect_run(2, 1, 7, 2); expect_run(2, 1, 2, 1);
    finish_stream("tff");

    // saturation split on zeros
    push_all(8'h00); push_all(8'h00);
    expect_run(0, 0, 16, 1);
    expect_run(1, 0, 16, 1);
    expect_run(2, 0, 7, 2); expect_run(2, 0, 2, 1);
    finish_stream("t00");

    // alternating bits: eight single-bit runs
    for (int k = 0; k < 3; k++) wc[k] = wr_cnt[k];
    push_all(8'hAA);
    for (int i = 0; i < 4; i++) begin
      expect_run(0, 0, 1, 1); expect_run(0, 1, 1, 1);
      expect_run(1, 1, 1, 1); expect_run(1, 0, 1, 1);
      expect_run(2, 0, 1, 1); expect_run(2, 1, 1, 1);
    end
    finish_stream("taa");
    for (int k = 0; k < 3; k++) check($sformatf("taa writes dut%0d", k), wr_cnt[k] - wc[k], 8);

    // output back-pressure at the first EMIT
    send_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      hold_bad[k] = 1'b0;
      eos[k] = 1'b1;
    end
    push_all(8'h0F);
    expect_run(0, 1, 4, 1); expect_run(0, 0, 4, 1);
    expect_run(1, 0, 4, 1); expect_run(1, 1, 4, 1);
    expect_run(2, 1, 4, 1); expect_run(2, 0, 4, 1);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c >= 10)
        for (int k = 0; k < 3; k++) if (wr_req[k] || rd_req[k]) hold_bad[k] = 1'b1;
    end
    for (int k = 0; k < 3; k++) check($sformatf("hold quiet dut%0d", k), hold_bad[k], 0);
    check("hold out_data dut0", od[0], enc(0, 1, 4));
    check("hold out_data dut1", od[1], enc(1, 0, 4));
    check("hold busy dut0", busy[0], 1);
    send_ready = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) check($sformatf("release wr_req dut%0d", k), wr_req[k], 1);
    finish_stream("thold");

    // reset mid-word, then an empty end_of_stream
    for (int k = 0; k < 3; k++) wc[k] = wr_cnt[k];
    push_all(8'h0F);
    repeat (5) @(negedge clk);
    check("mid-scan busy dut0", busy[0], 1);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_q[k].delete();
      recv_ready[k] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst mid out_data dut%0d", k), od[k], 0);
      check($sformatf("rst mid flags dut%0d", k), {30'd0, wr_req[k], busy[k]}, 0);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    finish_stream("trst");
    for (int k = 0; k < 3; k++) check($sformatf("trst writes dut%0d", k), wr_cnt[k] - wc[k], 0);

    for (int k = 0; k < 3; k++) check($sformatf("rd/wr overlap dut%0d", k), overlap[k], 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000 time units");
    $fatal(1, "watchdog");
  end

endmodule
